// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared fetch-side definitions: the NOP encoding driven to ID when no
// instruction is available, the default fetch PC after reset, and a helper
// that sizes occupancy counters. ID and the EX-stage monitor import the same
// package, so all three agree on these values.
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    // Encoding presented on id_instr while the queue head is empty.
    localparam logic [15:0] FQ_NOP_INSTR = 16'h0000;

    // Default fetch PC after reset.
    localparam logic [15:0] FQ_RESET_PC  = 16'h0000;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int unsigned fq_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// fetch_queue_fifo
// DEPTH-entry circular buffer holding {pc, instr} pairs for the fetch queue.
// A flush empties the queue in one cycle by moving the read pointer onto the
// write pointer; a flush overrides push and pop in the same cycle.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   push_i     in   write wr_data_i at the tail (never while full without pop)
//   pop_i      in   drop the head entry (never while empty)
//   flush_i    in   discard all entries
//   wr_data_i  in   entry to write
//   rd_data_o  out  head entry (registered storage, no path from wr_data_i)
//   rd_valid_o out  queue is non-empty
//   count_o    out  occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4      // power of two, >= 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic                          flush_i,
    input  logic [WIDTH-1:0]              wr_data_i,
    output logic [WIDTH-1:0]              rd_data_o,
    output logic                          rd_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = fq_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // NOTE: every next-state value gets a default first so no path leaves it
    // unassigned; without that, synthesis infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so +1 wraps at DEPTH.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; validity is tracked by count_q alone, and
    // leaving the array unreset lets it map onto plain RAM/register cells.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign rd_valid_o = (count_q != '0);
    assign count_o    = count_q;

endmodule : fetch_queue_fifo

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch front end. Owns the fetch PC, issues fetch addresses to
// the I-cache and buffers hit instructions with their PCs so that I-cache
// misses and ID stalls are decoupled. Redirects from the EX-stage monitor
// flush the queue and restart fetch at redirect_pc.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   i_addr       out  fetch address (the fetch PC register)
//   i_req        out  fetch request valid this cycle
//   i_hit        in   instr valid for i_addr this cycle
//   instr        in   instruction from the I-cache
//   redirect     in   flush queue, restart fetch at redirect_pc
//   redirect_pc  in   new fetch PC
//   stall        in   ID cannot accept the head entry this cycle
//   id_valid     out  head entry valid
//   id_instr     out  head instruction (NOP_INSTR when !id_valid)
//   id_pc        out  head PC (0 when !id_valid)
//   q_count      out  occupancy
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       INSTR_W   = 16,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(FQ_RESET_PC),
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(FQ_NOP_INSTR)
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [ADDR_W-1:0]           i_addr,
    output logic                        i_req,
    input  logic                        i_hit,
    input  logic [INSTR_W-1:0]          instr,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_pc,
    input  logic                        stall,
    output logic                        id_valid,
    output logic [INSTR_W-1:0]          id_instr,
    output logic [ADDR_W-1:0]           id_pc,
    output logic [$clog2(DEPTH+1)-1:0]  q_count
);

    localparam int unsigned CNT_W = fq_cnt_w(DEPTH);
    localparam int unsigned ENT_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              push, pop;
    logic              head_valid;
    logic [ENT_W-1:0]  head_data;

    // Redirect wins over everything: no pop, no fetch, same-cycle hit dropped.
    assign pop   = head_valid & ~stall & ~redirect;
    // A full queue that is draining this cycle still has room at the edge.
    assign i_req = ~redirect & ((q_count < CNT_W'(DEPTH)) | pop);
    assign push  = i_req & i_hit;

    always_comb begin
        fpc_d = fpc_q;
        if (redirect)  fpc_d = redirect_pc;
        else if (push) fpc_d = fpc_q + ADDR_W'(1);   // wraps at 2^ADDR_W
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fpc_q <= RESET_PC;
        else      fpc_q <= fpc_d;
    end

    assign i_addr = fpc_q;

    fetch_queue_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push_i     (push),
        .pop_i      (pop),
        .flush_i    (redirect),
        .wr_data_i  ({fpc_q, instr}),
        .rd_data_o  (head_data),
        .rd_valid_o (head_valid),
        .count_o    (q_count)
    );

    // Head outputs are masked so stale storage never leaks to ID.
    always_comb begin
        id_valid = head_valid;
        id_instr = NOP_INSTR;
        id_pc    = '0;
        if (head_valid) begin
            id_instr = head_data[INSTR_W-1:0];
            id_pc    = head_data[ENT_W-1:INSTR_W];
        end
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue. A queue-based reference model tracks
// the expected fetch PC and buffered {pc, instr} entries; each scenario task
// drives stimulus and compares the DUT against that model and against the
// directly known values of each scenario. A second instance with
// RESET_PC=16'hFFFE shares the stimulus and covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [15:0] NOP   = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_hit = 1'b0;
    logic [15:0] instr = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        stall = 1'b0;

    logic [15:0] i_addr, id_instr, id_pc;
    logic        i_req, id_valid;
    logic [2:0]  q_count;

    logic [15:0] w_i_addr, w_id_instr, w_id_pc;
    logic        w_i_req, w_id_valid;
    logic [2:0]  w_q_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i_req(i_req), .i_hit(i_hit),
        .instr(instr), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .q_count(q_count)
    );

    fetch_queue #(.RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst), .i_addr(w_i_addr), .i_req(w_i_req), .i_hit(i_hit),
        .instr(instr), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .id_valid(w_id_valid), .id_instr(w_id_instr),
        .id_pc(w_id_pc), .q_count(w_q_count)
    );

    // ---------------- reference model ----------------
    logic [31:0] mq[$];        // {pc, instr}, head at index 0
    logic [15:0] m_fpc;
    logic        m_pop, exp_req;
    logic [52:0] exp_v;
    logic [52:0] act_v;

    assign act_v = {id_valid, id_instr, id_pc, q_count, i_addr, i_req};

    task automatic compute_expected();
        logic        v;
        logic [31:0] head;
        v       = (mq.size() != 0);
        head    = v ? mq[0] : 32'h0;
        m_pop   = v && !stall && !redirect;
        exp_req = !redirect && ((mq.size() < DEPTH) || m_pop);
        exp_v   = {v, (v ? head[15:0] : NOP), (v ? head[31:16] : 16'h0),
                   3'(mq.size()), m_fpc, exp_req};
    endtask

    // Drive one cycle's inputs after the falling edge; expected values ready.
    task automatic drive(input logic h, input logic r, input logic [15:0] rpc,
                         input logic s);
        @(negedge clk);
        rst         = 1'b1;
        i_hit       = h;
        redirect    = r;
        redirect_pc = rpc;
        stall       = s;
        instr       = 16'($urandom);
        #1;
        compute_expected();
    endtask

    // Apply this cycle's effects to the model, then take the rising edge.
    task automatic advance();
        if (redirect) begin
            mq.delete();
            m_fpc = redirect_pc;
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (exp_req && i_hit) begin
                mq.push_back({m_fpc, instr});
                m_fpc = m_fpc + 16'd1;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; i_hit = 1'b0; redirect = 1'b0; stall = 1'b0;
        mq.delete();
        m_fpc = 16'h0000;
        #1;
        compute_expected();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (act_v !== exp_v || id_valid !== 1'b0 || id_instr !== NOP ||
            id_pc !== 16'h0 || q_count !== 3'd0 || i_addr !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_main got=%h exp=%h", act_v, exp_v);
        end
        n_checks++;
        if (w_i_addr !== 16'hFFFE || w_id_valid !== 1'b0 || w_q_count !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_wrapinst i_addr=%h valid=%b cnt=%0d exp FFFE/0/0",
                     w_i_addr, w_id_valid, w_q_count);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b0);
            n_checks++;
            if (act_v !== exp_v) begin
                n_errors++;
                $display("FAIL stream_vec cyc=%0d got=%h exp=%h", k, act_v, exp_v);
            end
            n_checks++;
            if (i_addr !== 16'(k) || q_count > 3'd1 ||
                (k > 0 && (id_valid !== 1'b1 || id_pc !== 16'(k - 1)))) begin
                n_errors++;
                $display("FAIL stream_seq cyc=%0d i_addr=%h id_pc=%h cnt=%0d", k, i_addr, id_pc, q_count);
            end
            advance();
        end
    endtask

    task automatic test_stall_fill();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b1);
            n_checks++;
            if (act_v !== exp_v) begin
                n_errors++;
                $display("FAIL stall_vec cyc=%0d got=%h exp=%h", k, act_v, exp_v);
            end
            if (k >= 4) begin
                n_checks++;
                if (q_count !== 3'd4 || i_req !== 1'b0 || i_addr !== 16'd4) begin
                    n_errors++;
                    $display("FAIL stall_full cyc=%0d cnt=%0d req=%b i_addr=%h exp 4/0/0004",
                             k, q_count, i_req, i_addr);
                end
            end
            advance();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b0);
            n_checks++;
            if (act_v !== exp_v || id_valid !== 1'b1 || id_pc !== 16'(k)) begin
                n_errors++;
                $display("FAIL stall_drain cyc=%0d id_pc=%h valid=%b exp pc=%h", k, id_pc, id_valid, 16'(k));
            end
            advance();
        end
    endtask

    task automatic test_miss();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b0);
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b0);
            n_checks++;
            if (act_v !== exp_v || i_addr !== 16'd5 || i_req !== 1'b1) begin
                n_errors++;
                $display("FAIL miss_hold cyc=%0d got=%h exp=%h", k, act_v, exp_v);
            end
            advance();
        end
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        advance();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++;
        if (act_v !== exp_v || id_valid !== 1'b1 || id_pc !== 16'd5 || i_addr !== 16'd6) begin
            n_errors++;
            $display("FAIL miss_then_hit id_pc=%h valid=%b i_addr=%h exp 0005/1/0006", id_pc, id_valid, i_addr);
        end
        advance();
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1'b0, 1'b1, 16'h0008, 1'b0);
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b1);
            advance();
        end
        drive(1'b1, 1'b1, 16'h0040, 1'b0);
        n_checks++;
        if (act_v !== exp_v || q_count !== 3'd3 || id_pc !== 16'h0008 || i_req !== 1'b0) begin
            n_errors++;
            $display("FAIL redir_cycle got=%h exp=%h", act_v, exp_v);
        end
        advance();
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        n_checks++;
        if (act_v !== exp_v || id_valid !== 1'b0 || i_addr !== 16'h0040 || q_count !== 3'd0) begin
            n_errors++;
            $display("FAIL redir_after valid=%b i_addr=%h cnt=%0d exp 0/0040/0", id_valid, i_addr, q_count);
        end
        advance();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++;
        if (act_v !== exp_v || id_valid !== 1'b1 || id_pc !== 16'h0040) begin
            n_errors++;
            $display("FAIL redir_first id_pc=%h valid=%b exp 0040/1", id_pc, id_valid);
        end
        advance();
        // Back-to-back redirects, then a redirect abandoning a miss.
        drive(1'b1, 1'b1, 16'h0100, 1'b0); advance();
        drive(1'b1, 1'b1, 16'h0200, 1'b0); advance();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++;
        if (act_v !== exp_v || i_addr !== 16'h0200 || q_count !== 3'd0) begin
            n_errors++;
            $display("FAIL redir_b2b i_addr=%h cnt=%0d exp 0200/0", i_addr, q_count);
        end
        advance();
        drive(1'b0, 1'b1, 16'h0300, 1'b0); advance();
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        n_checks++;
        if (act_v !== exp_v || i_addr !== 16'h0300) begin
            n_errors++;
            $display("FAIL redir_miss i_addr=%h exp 0300", i_addr);
        end
        advance();
    endtask

    task automatic test_full_flow();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b1);
            advance();
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b0);
            n_checks++;
            if (act_v !== exp_v || q_count !== 3'd4 || id_valid !== 1'b1 ||
                i_req !== 1'b1 || id_pc !== 16'(k)) begin
                n_errors++;
                $display("FAIL full_flow cyc=%0d cnt=%0d valid=%b req=%b id_pc=%h", k, q_count, id_valid, i_req, id_pc);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                  16'($urandom), $urandom_range(0, 2) == 0);
            n_checks++;
            if (act_v !== exp_v) begin
                n_errors++;
                $display("FAIL random_vec cyc=%0d got=%h exp=%h", k, act_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [15:0] ea;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b0);
            ea = 16'hFFFE + 16'(k);
            n_checks++;
            if (w_i_addr !== ea || (k > 0 && (w_id_valid !== 1'b1 || w_id_pc !== ea - 16'd1))) begin
                n_errors++;
                $display("FAIL wrap_seq cyc=%0d i_addr=%h id_pc=%h exp addr=%h", k, w_i_addr, w_id_pc, ea);
            end
            advance();
        end
        // Reset asserted in the middle of a cycle, away from either edge.
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 16'h0 ||
            q_count !== 3'd0 || i_addr !== 16'h0) begin
            n_errors++;
            $display("FAIL midreset_main got=%h", act_v);
        end
        n_checks++;
        if (w_id_valid !== 1'b0 || w_id_instr !== NOP || w_id_pc !== 16'h0 ||
            w_q_count !== 3'd0 || w_i_addr !== 16'hFFFE || w_i_req !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_wrap valid=%b instr=%h pc=%h cnt=%0d addr=%h req=%b",
                     w_id_valid, w_id_instr, w_id_pc, w_q_count, w_i_addr, w_i_req);
        end
        mq.delete();
        m_fpc = 16'h0000;
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL post_reset got=%h exp=%h", act_v, exp_v);
        end
        advance();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_miss();
        test_redirect();
        test_full_flow();
        test_random();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_fetch_queue
